seq_detect_param: RTL and testbench

Parametrised, runtime-programmable serial pattern detector. It generalises the fixed Moore sequence detector `seq` to a pattern of up to MAX_LEN bits with selectable length, overlapping or non-overlapping matching, an input-valid qualifier and a saturating match counter. It sits between a serial bit source and control logic that needs a registered one-cycle match flag plus a running match count.

---
 rtl/seq_detect_param.sv | 110 +++++++++++
 tb/tb_seq_detect_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector: selectable length, overlap mode,
// input-valid qualifier and a saturating match counter.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0000_1101),
    parameter int                 DEFAULT_LEN = 4,
    parameter int                 LEN_W       = $clog2(MAX_LEN+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d;
    logic               ovl_q, ovl_d, out_q, out_d, err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_n, win_mask;
    logic [LEN_W-1:0]   fill_n;
    logic               hit, cfg_ok;

    // Match evaluation on the candidate history; only the low len bits count.
    always_comb begin
        hist_n   = {hist_q[MAX_LEN-2:0], in};
        fill_n   = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_ONE;
        win_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            win_mask[i] = (LEN_W'(i) < len_q);
        end
        hit    = in_valid && !cfg_load && (fill_n >= len_q) &&
                 (((hist_n ^ pat_q) & win_mask) == '0);
        cfg_ok = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        out_d  = 1'b0;
        err_d  = 1'b0;
        cnt_d  = cnt_q;
        if (cfg_load) begin
            // Any bit offered alongside a load is dropped, legal or not.
            if (cfg_ok) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d = hist_n;
            fill_d = (hit && !ovl_q) ? '0 : fill_n;
            out_d  = hit;
        end
        if (cnt_clr) begin
            cnt_d = hit ? CNT_W'(1) : '0;
        end else if (hit && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEFAULT_PAT;
            len_q  <= LEN_W'(DEFAULT_LEN);
            ovl_q  <= 1'b1;
            out_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            out_q  <= out_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_sat   = &cnt_q;
    assign out       = out_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus randomized traffic checked
// against a queue-based model of the matching rules.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset, in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       out, cnt_sat, cfg_err, s_out, s_sat, s_err;
    logic [7:0] match_cnt;
    logic [1:0] s_cnt;

    int passed = 0;
    int total  = 0;

    // Model state: bits received since the last clear, newest at the back.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl, m_out, m_err;
    bit         m_q[$];
    int         m_cnt, m_cnt2;

    always #5 clk = ~clk;

    seq_detect_param u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out), .match_cnt(match_cnt), .cnt_sat(cnt_sat), .cfg_err(cfg_err)
    );

    seq_detect_param #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(s_out), .match_cnt(s_cnt), .cnt_sat(s_sat), .cfg_err(s_err)
    );

    task automatic model_update();
        bit hit = 0;
        if (reset) begin
            m_pat = 8'h0D; m_len = 4; m_ovl = 1;
            m_q.delete();
            m_out = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
            return;
        end
        m_err = 0;
        if (cfg_load) begin
            if (int'(cfg_len) >= 2 && int'(cfg_len) <= 8) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                m_q.delete();
            end else begin
                m_err = 1;
            end
        end else if (in_valid) begin
            m_q.push_back(in_bit);
            if (m_q.size() > 8) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
                hit = 1;
                for (int k = 0; k < m_len; k++)
                    if (m_q[m_q.size()-1-k] != m_pat[k]) hit = 0;
            end
            if (hit && !m_ovl) m_q.delete();
        end
        m_out = hit;
        if (cnt_clr) begin
            m_cnt  = hit ? 1 : 0;
            m_cnt2 = m_cnt;
        end else if (hit) begin
            m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
            m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
        end
    endtask

    // One clock: edge, model update, settle; strobes return to idle afterwards.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        reset = 0; cfg_load = 0; cnt_clr = 0; in_valid = 0;
    endtask

    task automatic send_bit(input bit b);
        in_valid = 1; in_bit = b;
        tick();
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input bit o, input bit clr);
        cfg_load = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cnt_clr = clr;
        tick();
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 1; in_bit = 1;
        tick();
        total++; if (out !== 1'b0) $display("FAIL rst_out got=%0b exp=0", out); else passed++;
        total++; if (match_cnt !== 8'd0) $display("FAIL rst_cnt got=%0d exp=0", match_cnt); else passed++;
        total++; if (cnt_sat !== 1'b0) $display("FAIL rst_sat got=%0b exp=0", cnt_sat); else passed++;
        total++; if (cfg_err !== 1'b0) $display("FAIL rst_err got=%0b exp=0", cfg_err); else passed++;
        total++; if (s_cnt !== 2'd0) $display("FAIL rst_cnt2 got=%0d exp=0", s_cnt); else passed++;
    endtask

    task automatic test_default_stream();
        logic [31:0] stream = 32'hD72DBEEF;
        int pulses = 0, first = -1;
        for (int i = 31; i >= 0; i--) begin
            send_bit(stream[i]);
            total++; if (out !== m_out) $display("FAIL dflt_out bit=%0d got=%0b exp=%0b", 31-i, out, m_out); else passed++;
            if (out === 1'b1) begin
                pulses++;
                if (first < 0) first = 31 - i;
            end
        end
        total++; if (pulses != 5) $display("FAIL dflt_pulses got=%0d exp=5", pulses); else passed++;
        total++; if (first != 3) $display("FAIL dflt_first got=%0d exp=3", first); else passed++;
        total++; if (match_cnt !== 8'd5) $display("FAIL dflt_cnt got=%0d exp=5", match_cnt); else passed++;
        total++; if (cnt_sat !== 1'b0) $display("FAIL dflt_sat got=%0b exp=0", cnt_sat); else passed++;
        total++; if (s_cnt !== 2'd3) $display("FAIL sat_cnt2 got=%0d exp=3", s_cnt); else passed++;
        total++; if (s_sat !== 1'b1) $display("FAIL sat_flag2 got=%0b exp=1", s_sat); else passed++;
    endtask

    task automatic test_cnt_clr_hit();
        send_bit(1); send_bit(1); send_bit(0);
        in_valid = 1; in_bit = 1; cnt_clr = 1;
        tick();
        total++; if (out !== 1'b1) $display("FAIL clrhit_out got=%0b exp=1", out); else passed++;
        total++; if (match_cnt !== 8'd1) $display("FAIL clrhit_cnt got=%0d exp=1", match_cnt); else passed++;
        total++; if (s_cnt !== 2'd1) $display("FAIL clrhit_cnt2 got=%0d exp=1", s_cnt); else passed++;
        total++; if (s_sat !== 1'b0) $display("FAIL clrhit_sat2 got=%0b exp=0", s_sat); else passed++;
    endtask

    task automatic test_nonoverlap();
        logic [31:0] stream = 32'hD72DBEEF;
        int pulses = 0;
        bit hit18 = 0;
        load_cfg(8'h0D, 4'd4, 1'b0, 1'b1);
        for (int i = 31; i >= 0; i--) begin
            send_bit(stream[i]);
            total++; if (out !== m_out) $display("FAIL novl_out bit=%0d got=%0b exp=%0b", 31-i, out, m_out); else passed++;
            if (out === 1'b1) pulses++;
            if (31 - i == 18 && out === 1'b1) hit18 = 1;
        end
        total++; if (pulses != 4) $display("FAIL novl_pulses got=%0d exp=4", pulses); else passed++;
        total++; if (match_cnt !== 8'd4) $display("FAIL novl_cnt got=%0d exp=4", match_cnt); else passed++;
        total++; if (hit18) $display("FAIL novl_bit18 got=1 exp=0"); else passed++;
    endtask

    task automatic test_short_pattern();
        logic [4:0] stream = 5'b10101;
        for (int o = 1; o >= 0; o--) begin
            int pulses = 0;
            load_cfg(8'b101, 4'd3, o[0], 1'b1);
            for (int i = 4; i >= 0; i--) begin
                send_bit(stream[i]);
                if (out === 1'b1) pulses++;
            end
            total++; if (pulses != (o ? 2 : 1)) $display("FAIL short_pulses ovl=%0d got=%0d exp=%0d", o, pulses, o ? 2 : 1); else passed++;
            total++; if (int'(match_cnt) != (o ? 2 : 1)) $display("FAIL short_cnt ovl=%0d got=%0d exp=%0d", o, match_cnt, o ? 2 : 1); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] pat = 4'b1101;
        int pulses = 0;
        reset = 1; tick();
        send_bit(1); send_bit(1); send_bit(0);
        reset = 1; tick();
        send_bit(1);
        total++; if (out !== 1'b0) $display("FAIL rmid_nopulse got=%0b exp=0", out); else passed++;
        for (int i = 3; i >= 0; i--) begin
            send_bit(pat[i]);
            if (out === 1'b1) pulses++;
        end
        total++; if (pulses != 1) $display("FAIL rmid_pulses got=%0d exp=1", pulses); else passed++;
        total++; if (out !== 1'b1) $display("FAIL rmid_last got=%0b exp=1", out); else passed++;
    endtask

    task automatic test_illegal_cfg();
        reset = 1; tick();
        send_bit(1); send_bit(1); send_bit(0);
        for (int n = 0; n < 2; n++) begin
            cfg_load = 1; cfg_pattern = 8'hFF; cfg_overlap = 0;
            cfg_len = (n == 0) ? 4'd0 : 4'd9;
            in_valid = 1; in_bit = 0;
            tick();
            total++; if (cfg_err !== 1'b1) $display("FAIL bad_err len=%0d got=%0b exp=1", cfg_len, cfg_err); else passed++;
            total++; if (out !== 1'b0) $display("FAIL bad_out len=%0d got=%0b exp=0", cfg_len, out); else passed++;
        end
        tick();
        total++; if (cfg_err !== 1'b0) $display("FAIL bad_err_clear got=%0b exp=0", cfg_err); else passed++;
        send_bit(1);
        total++; if (out !== 1'b1) $display("FAIL bad_keep got=%0b exp=1", out); else passed++;
    endtask

    task automatic test_random();
        reset = 1; tick();
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_bit   = $urandom_range(0, 1);
            cnt_clr  = ($urandom_range(0, 39) == 0);
            cfg_load = ($urandom_range(0, 29) == 0);
            cfg_pattern = 8'($urandom);
            cfg_overlap = $urandom_range(0, 1);
            cfg_len  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(2, 3));
            tick();
            total++; if (out !== m_out) $display("FAIL rnd_out cyc=%0d got=%0b exp=%0b", c, out, m_out); else passed++;
            total++; if (int'(match_cnt) != m_cnt) $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, match_cnt, m_cnt); else passed++;
            total++; if (cnt_sat !== (m_cnt == 255)) $display("FAIL rnd_sat cyc=%0d got=%0b exp=%0b", c, cnt_sat, m_cnt == 255); else passed++;
            total++; if (cfg_err !== m_err) $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", c, cfg_err, m_err); else passed++;
            total++; if (int'(s_cnt) != m_cnt2) $display("FAIL rnd_cnt2 cyc=%0d got=%0d exp=%0d", c, s_cnt, m_cnt2); else passed++;
            total++; if (s_sat !== (m_cnt2 == 3)) $display("FAIL rnd_sat2 cyc=%0d got=%0b exp=%0b", c, s_sat, m_cnt2 == 3); else passed++;
        end
    endtask

    initial begin
        reset = 0; in_valid = 0; in_bit = 0; cfg_load = 0; cnt_clr = 0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 0;
        #2;
        test_reset();
        test_default_stream();
        test_cnt_clr_hit();
        test_nonoverlap();
        test_short_pattern();
        test_reset_mid();
        test_illegal_cfg();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
